// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/gnt/rvalid bus handshake, byte-lane steering, load extension.
// Optional `define LSU_TIMEOUT_EN aborts a WAIT that lasts TIMEOUT cycles and raises sticky bus_err.
module load_store_unit #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] writeDataM,
    output logic [31:0] ReadDataM,
    output logic        lsu_stallM,
    output logic        misalignM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        stall_c;
    logic        access_vld;
    logic        access_flt;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ERR_DATA, 32'(TIMEOUT)};
`endif

    function automatic logic is_fault(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b001, 3'b101:         return a[0];
            3'b010:                 return |a;
            3'b011, 3'b110, 3'b111: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // A simultaneous read and write is treated as a write.
    assign access_vld = MemReadM | MemWriteM;
    assign access_flt = is_fault(funct3M, ALUResultM[1:0]);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        stall_c    = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (access_vld) begin
                    if (access_flt) begin
                        misalign_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        addr_d  = ALUResultM;
                        be_d    = lane_be(funct3M, ALUResultM[1:0]);
                        we_d    = MemWriteM;
                        wdata_d = lane_wdata(funct3M, writeDataM);
                        f3_d    = funct3M;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (bus_gnt) begin
                    if (bus_rvalid) begin
                        state_d = S_DONE;
                        if (!we_q) rdata_d = load_extract(f3_q, addr_q[1:0], bus_rdata);
                    end else begin
                        state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = load_extract(f3_q, addr_q[1:0], bus_rdata);
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            // DONE releases the stall for one cycle and accepts nothing new.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            f3_q       <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign ReadDataM  = rdata_q;
    assign lsu_stallM = reset & stall_c;
    assign misalignM  = misalign_q;
    assign bus_req    = (state_q == S_REQ);
    assign bus_we     = we_q;
    assign bus_addr   = {addr_q[31:2], 2'b00};
    assign bus_be     = be_q;
    assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses vs. a lane-arithmetic model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  funct3M = 3'b000;
    logic [31:0] ALUResultM = '0, writeDataM = '0;
    logic [31:0] ReadDataM;
    logic        lsu_stallM, misalignM;
    logic        bus_req, bus_we, bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
    logic [3:0]  bus_be;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_rd  = '0;

    load_store_unit #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .writeDataM(writeDataM),
        .ReadDataM(ReadDataM), .lsu_stallM(lsu_stallM), .misalignM(misalignM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: access width in bytes, lane offset by integer arithmetic.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_fault(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic [31:0] m_mask(input logic [2:0] f3);
        int n = nbytes(f3);
        return (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return 4'(((1 << n) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = nbytes(f3);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i += n) r |= (wd & m_mask(f3)) << (8 * i);
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int n = nbytes(f3);
        logic [31:0] v = (rd >> (8 * m_off(f3, a))) & m_mask(f3);
        if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1) v |= ~m_mask(f3);
        return v;
    endfunction

    // One complete access: gd cycles of REQ without grant (with stray rvalid), then grant;
    // rvd = 0 means rvalid with the grant, otherwise rvalid on the rvd-th WAIT cycle.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int rvd,
                          input logic [31:0] rdat);
        bit flt = m_fault(f3, a);
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; writeDataM = wd;
        #1 check("stall_idle", 32'(lsu_stallM), 32'(!flt));
        if (flt) begin
            @(negedge clk);
            check("misalign_pulse", 32'(misalignM), 32'd1);
            check("flt_no_req", 32'(bus_req), 32'd0);
            check("flt_no_stall", 32'(lsu_stallM), 32'd0);
            MemReadM = 1'b0; MemWriteM = 1'b0;
            @(negedge clk);
            check("misalign_clear", 32'(misalignM), 32'd0);
            check("flt_rd_hold", ReadDataM, exp_rd);
            return;
        end
        @(negedge clk);
        check("req", 32'(bus_req), 32'd1);
        check("addr", bus_addr, a & 32'hFFFF_FFFC);
        check("be", 32'(bus_be), 32'(m_be(f3, a)));
        check("we", 32'(bus_we), 32'(wr));
        if (wr) check("wdata", bus_wdata, m_wdata(f3, wd));
        for (int i = 0; i < gd; i++) begin
            bus_rvalid = 1'b1; bus_rdata = $urandom;
            @(negedge clk);
            check("req_hold", 32'(bus_req), 32'd1);
            check("addr_hold", bus_addr, a & 32'hFFFF_FFFC);
            check("stall_req", 32'(lsu_stallM), 32'd1);
        end
        bus_gnt = 1'b1; bus_rvalid = (rvd == 0); bus_rdata = rdat;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (rvd > 0) begin
            check("wait_no_req", 32'(bus_req), 32'd0);
            check("wait_stall", 32'(lsu_stallM), 32'd1);
            for (int i = 1; i < rvd; i++) @(negedge clk);
            bus_rvalid = 1'b1; bus_rdata = rdat;
            @(negedge clk);
            bus_rvalid = 1'b0;
        end
        if (!wr) exp_rd = m_load(f3, a, rdat);
        check("done_stall", 32'(lsu_stallM), 32'd0);
        check("done_rdata", ReadDataM, exp_rd);
        check("done_no_req", 32'(bus_req), 32'd0);
        MemReadM = 1'b0; MemWriteM = 1'b0;
        @(negedge clk);
        check("idle_stall", 32'(lsu_stallM), 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind;
        logic [2:0]  legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        // Reset state with a pending load on the inputs.
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h100;
        @(negedge clk);
        check("rst_stall", 32'(lsu_stallM), 32'd0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_misalign", 32'(misalignM), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h1234_5678);
        access(1, 0, 3'b000, 32'h203, 32'h0, 3, 2, 32'h80FF_FFFF);
        access(1, 0, 3'b100, 32'h203, 32'h0, 3, 2, 32'h80FF_FFFF);
        access(0, 1, 3'b001, 32'h302, 32'hAAAA_BEEF, 1, 1, 32'h5555_5555);
        access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
        access(0, 1, 3'b001, 32'h003, 32'h1234, 0, 0, 32'h0);
        access(1, 0, 3'b110, 32'h400, 32'h0, 0, 0, 32'h0);

        // Reset while waiting for the response.
        @(negedge clk);
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h500;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check("wait_before_rst", 32'(lsu_stallM), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_req", 32'(bus_req), 32'd0);
        check("midrst_stall", 32'(lsu_stallM), 32'd0);
        check("midrst_rdata", ReadDataM, 32'd0);
        check("midrst_addr", bus_addr, 32'd0);
        check("midrst_be", 32'(bus_be), 32'd0);
        exp_rd = '0;
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access(1, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 0, 1, 32'h0);

        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) f3 = 3'd3 + 3'($urandom_range(0, 1) * 3 + $urandom_range(0, 1));
            else if (kind == 0) f3 = legal_ld[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            access(kind != 1, kind != 0, f3, a, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom);
        end

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h600;
        @(negedge clk);
        check("tmo_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_wait_stall", 32'(lsu_stallM), 32'd1);
            @(negedge clk);
        end
        check("tmo_done_stall", 32'(lsu_stallM), 32'd0);
        check("tmo_rdata", ReadDataM, 32'hDEAD_BEEF);
        check("tmo_err", 32'(bus_err), 32'd1);
        exp_rd = 32'hDEAD_BEEF;
        MemReadM = 1'b0;
        access(0, 1, 3'b010, 32'h700, 32'h1111_2222, 0, 1, 32'h0);
        check("tmo_err_sticky", 32'(bus_err), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1 check("tmo_err_rst", 32'(bus_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
`else
        access(1, 0, 3'b101, 32'h702, 32'h0, 0, 12, 32'hF00D_8001);
        check("no_err", 32'(bus_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
